// File: rtl/fp_pkg.sv
// Shared floating-point definitions: formats, classifier flag indices,
// rounding modes, fflags positions, canonical constants, divider states.
package fp_pkg;
  localparam int NSIG = 23;
  localparam int NEXP = 8;
  localparam int BIAS = 127;

  // Classifier flag vector bit indices
  localparam int SNAN        = 0;
  localparam int QNAN        = 1;
  localparam int P_INF       = 2;
  localparam int P_ZERO      = 3;
  localparam int P_SUBNORMAL = 4;
  localparam int P_NORMAL    = 5;
  localparam int N_INF       = 6;
  localparam int N_ZERO      = 7;
  localparam int N_SUBNORMAL = 8;
  localparam int N_NORMAL    = 9;
  localparam int NCLASS      = 10;

  // RISC-V rounding modes
  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  // fflags bit positions {NV,DZ,OF,UF,NX}
  localparam int FF_NX = 0;
  localparam int FF_UF = 1;
  localparam int FF_OF = 2;
  localparam int FF_DZ = 3;
  localparam int FF_NV = 4;

  localparam logic [NSIG+NEXP:0] CANON_NAN  = 32'h7FC0_0000;
  localparam logic [NSIG+NEXP:0] MAX_FINITE = 32'h7F7F_FFFF;

  // Divider FSM states
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_DIV  = 2'd1;
  localparam state_t S_RND  = 2'd2;
  localparam state_t S_DONE = 2'd3;
endpackage

// File: rtl/fp_round_pack.sv
// Combinational round-and-pack: denormalises tiny results, rounds per
// RISC-V frm, packs binary32 and reports OF/UF/NX. Shared by div/mul/sqrt.
module fp_round_pack
  import fp_pkg::*;
#(
  parameter int QBITS = NSIG + 4
) (
  input  logic                   i_sign,
  input  logic [NEXP+2:0]        i_exp,     // signed biased exponent
  input  logic [QBITS-1:0]       i_sig,     // 1.f with integer bit at top
  input  logic                   i_sticky,
  input  logic [2:0]             i_frm,
  output logic [NSIG+NEXP:0]     o_result,
  output logic                   o_of,
  output logic                   o_uf,
  output logic                   o_nx
);
  localparam int SHW = $clog2(QBITS + 2);
  localparam logic signed [NEXP+2:0] SH_MAX = (NEXP+3)'(QBITS + 1);
  localparam logic signed [NEXP+2:0] E_MAX  = (NEXP+3)'(2**NEXP - 1);

  logic signed [NEXP+2:0] w_exp, w_sh_full, w_ew, w_exp_out;
  logic                   w_tiny, w_inc, w_g, w_st, w_lost;
  logic [SHW-1:0]         w_sh;
  logic [2*QBITS:0]       w_shifted;
  logic [QBITS-1:0]       w_sig;
  logic [NSIG:0]          w_m;
  logic [NSIG+1:0]        w_mr;

  assign w_exp     = $signed(i_exp);
  assign w_tiny    = (w_exp <= 0);
  assign w_sh_full = (NEXP+3)'(1) - w_exp;
  // Tiny results shift right by 1-e; anything past QBITS+1 is all sticky
  assign w_sh      = !w_tiny ? '0 :
                     (w_sh_full > SH_MAX) ? SHW'(QBITS + 1) : w_sh_full[SHW-1:0];
  assign w_shifted = {i_sig, {(QBITS+1){1'b0}}} >> w_sh;
  assign w_sig     = w_shifted[2*QBITS:QBITS+1];
  assign w_lost    = |w_shifted[QBITS:0];

  assign w_m  = w_sig[QBITS-1 -: NSIG+1];
  assign w_g  = w_sig[QBITS-NSIG-2];
  assign w_st = (|w_sig[QBITS-NSIG-3:0]) | i_sticky | w_lost;

  // Rounding increment; unknown modes fall back to RNE
  always_comb begin
    w_inc = 1'b0;
    case (i_frm)
      RM_RTZ:  w_inc = 1'b0;
      RM_RDN:  w_inc = i_sign & (w_g | w_st);
      RM_RUP:  w_inc = ~i_sign & (w_g | w_st);
      RM_RMM:  w_inc = w_g;
      default: w_inc = w_g & (w_st | w_m[0]);
    endcase
  end

  assign w_mr = {1'b0, w_m} + (NSIG+2)'(w_inc);
  assign w_ew = w_tiny ? '0 : w_exp;

  // Exponent after rounding: carry bumps it, subnormal rounding into the
  // hidden bit lands on the minimum normal exponent
  always_comb begin
    if (w_mr[NSIG+1])  w_exp_out = w_ew + (NEXP+3)'(1);
    else if (w_tiny)   w_exp_out = $signed({{(NEXP+2){1'b0}}, w_mr[NSIG]});
    else               w_exp_out = w_ew;
  end

  assign o_of = (w_exp_out >= E_MAX);
  assign o_nx = w_g | w_st | o_of;
  assign o_uf = (w_exp_out == 0) & o_nx;

  // Overflow picks inf or largest finite depending on direction
  always_comb begin
    o_result = {i_sign, w_exp_out[NEXP-1:0], w_mr[NSIG-1:0]};
    if (o_of) begin
      if ((i_frm == RM_RTZ) || (i_frm == RM_RDN && !i_sign) || (i_frm == RM_RUP && i_sign))
        o_result = {i_sign, MAX_FINITE[NSIG+NEXP-1:0]};
      else
        o_result = {i_sign, {NEXP{1'b1}}, {NSIG{1'b0}}};
    end
  end
endmodule

// File: rtl/fp_div_iter.sv
// Iterative binary32 divider, radix-2 restoring, valid/ready both sides.
// Optional FP_DIV_POW2_SHORTCUT_EN: power-of-two divisors skip the
// recurrence (same results and flags, latency 2 instead of 29).
module fp_div_iter
  import fp_pkg::*;
#(
  parameter int QBITS = NSIG + 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_flush,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  input  logic [NSIG+NEXP:0] i_a_flags,
  input  logic [NEXP+1:0]    i_a_exp,
  input  logic [NSIG:0]      i_a_sig,
  input  logic [NSIG+NEXP:0] i_b_flags,
  input  logic [NEXP+1:0]    i_b_exp,
  input  logic [NSIG:0]      i_b_sig,
  input  logic [2:0]         i_frm,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [NSIG+NEXP:0] o_result,
  output logic [4:0]         o_fflags
);
  localparam int CNTW = $clog2(QBITS);

  state_t                 r_state;
  logic                   r_sign;
  logic [2:0]             r_frm;
  logic signed [NEXP+2:0] r_exp;
  logic [NSIG+2:0]        r_rem;
  logic [NSIG:0]          r_div;
  logic [QBITS-1:0]       r_q;
  logic [CNTW-1:0]        r_cnt;
  logic [NSIG+NEXP:0]     r_result;
  logic [4:0]             r_fflags;

  logic w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero, w_sign;
  logic w_special, w_unused_flags;
  logic [NSIG+NEXP:0] w_sp_res, w_inf, w_zero;
  logic [4:0]         w_sp_flags;
  logic signed [NEXP+2:0] w_exp_in, w_rnd_exp;
  logic [NSIG+3:0]    w_diff;
  logic               w_qbit;
  logic [NSIG+2:0]    w_rsel;
  logic [QBITS-1:0]   w_rnd_sig;
  logic [NSIG+NEXP:0] w_rp_result;
  logic               w_of, w_uf, w_nx;

  assign w_unused_flags = ^{i_a_flags[NSIG+NEXP:NCLASS], i_b_flags[NSIG+NEXP:NCLASS],
                            i_a_flags[P_NORMAL], i_a_flags[P_SUBNORMAL],
                            i_b_flags[P_NORMAL], i_b_flags[P_SUBNORMAL]};

  assign w_a_nan  = i_a_flags[SNAN] | i_a_flags[QNAN];
  assign w_b_nan  = i_b_flags[SNAN] | i_b_flags[QNAN];
  assign w_a_inf  = i_a_flags[P_INF] | i_a_flags[N_INF];
  assign w_b_inf  = i_b_flags[P_INF] | i_b_flags[N_INF];
  assign w_a_zero = i_a_flags[P_ZERO] | i_a_flags[N_ZERO];
  assign w_b_zero = i_b_flags[P_ZERO] | i_b_flags[N_ZERO];
  assign w_sign   = (i_a_flags[N_INF] | i_a_flags[N_ZERO] | i_a_flags[N_SUBNORMAL] | i_a_flags[N_NORMAL])
                  ^ (i_b_flags[N_INF] | i_b_flags[N_ZERO] | i_b_flags[N_SUBNORMAL] | i_b_flags[N_NORMAL]);
  assign w_inf    = {w_sign, {NEXP{1'b1}}, {NSIG{1'b0}}};
  assign w_zero   = {w_sign, {(NSIG+NEXP){1'b0}}};

  // Special-case decode, ordered so NaN and invalid forms take priority
  always_comb begin
    w_special  = 1'b1;
    w_sp_res   = CANON_NAN;
    w_sp_flags = '0;
    if (w_a_nan || w_b_nan)
      w_sp_flags[FF_NV] = i_a_flags[SNAN] | i_b_flags[SNAN];
    else if ((w_a_zero && w_b_zero) || (w_a_inf && w_b_inf))
      w_sp_flags[FF_NV] = 1'b1;
    else if (w_a_inf)
      w_sp_res = w_inf;
    else if (w_b_zero) begin
      w_sp_res          = w_inf;
      w_sp_flags[FF_DZ] = 1'b1;
    end else if (w_a_zero || w_b_inf)
      w_sp_res = w_zero;
    else
      w_special = 1'b0;
  end

  assign w_exp_in = $signed({i_a_exp[NEXP+1], i_a_exp}) - $signed({i_b_exp[NEXP+1], i_b_exp})
                  + (NEXP+3)'(BIAS);

  // One restoring step: keep the difference when it does not borrow
  assign w_diff = {1'b0, r_rem} - {3'b000, r_div};
  assign w_qbit = ~w_diff[NSIG+3];
  assign w_rsel = w_qbit ? w_diff[NSIG+2:0] : r_rem;

  // Quotient lies in (0.5, 2); a clear integer bit needs one left shift
  assign w_rnd_sig = r_q[QBITS-1] ? r_q : (r_q << 1);
  assign w_rnd_exp = r_q[QBITS-1] ? r_exp : r_exp - (NEXP+3)'(1);

  fp_round_pack #(.QBITS(QBITS)) u_rp (
    .i_sign   (r_sign),
    .i_exp    (w_rnd_exp),
    .i_sig    (w_rnd_sig),
    .i_sticky (r_rem != '0),
    .i_frm    (r_frm),
    .o_result (w_rp_result),
    .o_of     (w_of),
    .o_uf     (w_uf),
    .o_nx     (w_nx)
  );

  // Control FSM and datapath registers; flush overrides every transition
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_sign   <= 1'b0;
      r_frm    <= '0;
      r_exp    <= '0;
      r_rem    <= '0;
      r_div    <= '0;
      r_q      <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_fflags <= '0;
    end else if (i_flush) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (i_in_valid) begin
          r_sign <= w_sign;
          r_frm  <= i_frm;
          r_exp  <= w_exp_in;
          if (w_special) begin
            r_result <= w_sp_res;
            r_fflags <= w_sp_flags;
            r_state  <= S_DONE;
          end
`ifdef FP_DIV_POW2_SHORTCUT_EN
          else if (i_b_sig == {1'b1, {NSIG{1'b0}}}) begin
            r_q     <= {i_a_sig, {(QBITS-NSIG-1){1'b0}}};
            r_rem   <= '0;
            r_state <= S_RND;
          end
`endif
          else begin
            r_rem   <= {2'b00, i_a_sig};
            r_div   <= i_b_sig;
            r_q     <= '0;
            r_cnt   <= CNTW'(QBITS - 1);
            r_state <= S_DIV;
          end
        end
        S_DIV: begin
          r_q   <= {r_q[QBITS-2:0], w_qbit};
          r_rem <= w_rsel << 1;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) r_state <= S_RND;
        end
        S_RND: begin
          r_result <= w_rp_result;
          r_fflags <= {2'b00, w_of, w_uf, w_nx};
          r_state  <= S_DONE;
        end
        S_DONE: if (i_out_ready) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_in_ready  = (r_state == S_IDLE);
  assign o_out_valid = (r_state == S_DONE);
  assign o_result    = r_result;
  assign o_fflags    = r_fflags;
endmodule

// File: tb/tb_fp_div_iter.sv
// Directed bench for fp_div_iter: vector table plus handshake, flush and
// async-reset sequences. Expected latency follows FP_DIV_POW2_SHORTCUT_EN.
module tb_fp_div_iter;
  import fp_pkg::*;

`ifdef FP_DIV_POW2_SHORTCUT_EN
  localparam bit SC = 1'b1;
`else
  localparam bit SC = 1'b0;
`endif

  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid;
  logic [31:0] a_flags = '0, b_flags = '0, result;
  logic [9:0]  a_exp = '0, b_exp = '0;
  logic [23:0] a_sig = '0, b_sig = '0;
  logic [2:0]  frm = '0;
  logic [4:0]  fflags;

  int errors = 0, checks = 0;

  fp_div_iter dut (
    .clk(clk), .rst_n(rst_n), .i_flush(flush), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_a_flags(a_flags), .i_a_exp(a_exp), .i_a_sig(a_sig),
    .i_b_flags(b_flags), .i_b_exp(b_exp), .i_b_sig(b_sig),
    .i_frm(frm), .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_result(result), .o_fflags(fflags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a, b;
    logic [2:0]  frm;
    logic [31:0] res;
    logic [4:0]  ff;
    bit          special;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference classifier: binary32 -> flags / unbiased exponent / 1.f
  task automatic unpack(input logic [31:0] x, output logic [31:0] fl,
                        output logic [9:0] e, output logic [23:0] s);
    logic [23:0] m;
    int sh;
    fl = '0; e = '0; s = '0;
    if (x[30:23] == 8'hFF) begin
      if (x[22:0] == 0) fl[x[31] ? N_INF : P_INF] = 1'b1;
      else if (x[22])   fl[QNAN] = 1'b1;
      else              fl[SNAN] = 1'b1;
    end else if (x[30:23] == 8'h00) begin
      if (x[22:0] == 0) fl[x[31] ? N_ZERO : P_ZERO] = 1'b1;
      else begin
        fl[x[31] ? N_SUBNORMAL : P_SUBNORMAL] = 1'b1;
        m = {1'b0, x[22:0]}; sh = 0;
        while (!m[23]) begin m = m << 1; sh++; end
        s = m; e = 10'(-126 - sh);
      end
    end else begin
      fl[x[31] ? N_NORMAL : P_NORMAL] = 1'b1;
      s = {1'b1, x[22:0]}; e = 10'(int'(x[30:23]) - 127);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm);
    unpack(a, a_flags, a_exp, a_sig);
    unpack(b, b_flags, b_exp, b_sig);
    frm = rm;
    in_valid = 1'b1;
  endtask

  // Called #1 after the accept edge; counts edges until out_valid
  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    if (!out_valid) begin
      checks++; errors++;
      $display("FAIL timeout: out_valid low after %0d edges, expected high", lat);
    end
  endtask

  task automatic run(input vec_t v, input string name);
    int lat, exp_lat;
    drive(v.a, v.b, v.frm);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(lat);
    exp_lat = v.special ? 1 : ((SC && v.b[22:0] == 0 && v.b[30:23] != 0) ? 2 : 29);
    chk({name, " result"}, result, v.res);
    chk({name, " fflags"}, {27'd0, fflags}, {27'd0, v.ff});
    chk({name, " latency"}, lat, exp_lat);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  function automatic vec_t mk(logic [31:0] a, logic [31:0] b, logic [2:0] rm,
                              logic [31:0] res, logic [4:0] ff, bit sp);
    vec_t v;
    v.a = a; v.b = b; v.frm = rm; v.res = res; v.ff = ff; v.special = sp;
    return v;
  endfunction

  vec_t vecs[$];
  vec_t v62;
  int   lat;
  bit   seen;

  initial begin
    v62 = mk(32'h40C00000, 32'h40000000, RM_RNE, 32'h40400000, 5'h00, 0);
    vecs.push_back(v62);
    vecs.push_back(mk(32'h3F800000, 32'h40400000, RM_RNE, 32'h3EAAAAAB, 5'h01, 0));
    vecs.push_back(mk(32'h3F800000, 32'h40400000, RM_RTZ, 32'h3EAAAAAA, 5'h01, 0));
    vecs.push_back(mk(32'h3F800000, 32'h40400000, 3'b111, 32'h3EAAAAAB, 5'h01, 0));
    vecs.push_back(mk(32'hBF800000, 32'h40400000, RM_RDN, 32'hBEAAAAAB, 5'h01, 0));
    vecs.push_back(mk(32'hBF800000, 32'h40400000, RM_RUP, 32'hBEAAAAAA, 5'h01, 0));
    vecs.push_back(mk(32'h3F800000, 32'h00000000, RM_RNE, 32'h7F800000, 5'h08, 1));
    vecs.push_back(mk(32'h00000000, 32'h00000000, RM_RNE, 32'h7FC00000, 5'h10, 1));
    vecs.push_back(mk(32'h7FA00000, 32'h3F800000, RM_RNE, 32'h7FC00000, 5'h10, 1));
    vecs.push_back(mk(32'h7FC00000, 32'h3F800000, RM_RNE, 32'h7FC00000, 5'h00, 1));
    vecs.push_back(mk(32'hFF800000, 32'h40000000, RM_RNE, 32'hFF800000, 5'h00, 1));
    vecs.push_back(mk(32'hC0400000, 32'h7F800000, RM_RNE, 32'h80000000, 5'h00, 1));
    vecs.push_back(mk(32'h00800000, 32'h40000000, RM_RNE, 32'h00400000, 5'h00, 0));
    vecs.push_back(mk(32'h00000001, 32'h40000000, RM_RNE, 32'h00000000, 5'h03, 0));
    vecs.push_back(mk(32'h00000001, 32'h40000000, RM_RUP, 32'h00000001, 5'h03, 0));
    vecs.push_back(mk(32'h7F7FFFFF, 32'h3F000000, RM_RNE, 32'h7F800000, 5'h05, 0));
    vecs.push_back(mk(32'h7F7FFFFF, 32'h3F000000, RM_RTZ, 32'h7F7FFFFF, 5'h05, 0));
    vecs.push_back(mk(32'h7F7FFFFF, 32'h3F000000, RM_RDN, 32'h7F7FFFFF, 5'h05, 0));
    vecs.push_back(mk(32'hFF7FFFFF, 32'h3F000000, RM_RUP, 32'hFF7FFFFF, 5'h05, 0));

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset result", result, 32'd0);
    chk("reset fflags", {27'd0, fflags}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) run(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: result must hold while out_ready stays low
    drive(v62.a, v62.b, v62.frm);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(lat);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("hold%0d result", k), result, 32'h40400000);
      chk($sformatf("hold%0d ready/valid", k), {30'd0, in_ready, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("release idle", {30'd0, in_ready, out_valid}, 32'd2);
    drive(32'h3F800000, 32'h40400000, RM_RNE);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("next accepted", {31'd0, in_ready}, 32'd0);
    wait_out(lat);
    chk("next result", result, 32'h3EAAAAAB);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Flush mid-iteration: no output, back to idle, next op clean
    drive(32'h3F800000, 32'h40400000, RM_RNE);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush idle", {30'd0, in_ready, out_valid}, 32'd2);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("flush no out_valid", {31'd0, seen}, 32'd0);
    run(v62, "post-flush");

    // Async reset mid-iteration: outputs return to reset values at once
    drive(32'h3F800000, 32'h40400000, RM_RNE);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst ready/valid", {30'd0, in_ready, out_valid}, 32'd2);
    chk("midrst result", result, 32'd0);
    chk("midrst fflags", {27'd0, fflags}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run(vecs[1], "post-reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fp_div_iter.md
Name: fp_div_iter

Overview:
- Iterative single-precision divider, directly downstream of the fp classifier.
- Consumes two unpacked operands: the class flag vector, the unbiased signed exponent and the 24-bit significant with its leading one restored (subnormals arrive pre-normalised).
- Produces a packed IEEE-754 binary32 quotient plus RISC-V fflags.
- Uses a radix-2 restoring recurrence, RISC-V rounding modes and a valid/ready handshake on both sides.

Parameters:
- NSIG, 23, fraction width.
- NEXP, 8, exponent width.
- QBITS, 27, quotient bits generated: 1 integer, 23 fraction, 1 normalisation spare, guard, round.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous abort
- in_valid  in  1  operand pair valid
- in_ready  out  1  divider can accept
- a_flags  in  NSIG+NEXP+1  dividend class flags, classifier bit indices
- a_exp  in  NEXP+2 signed  dividend unbiased exponent
- a_sig  in  NSIG+1  dividend significand 1.f
- b_flags, b_exp, b_sig  in  same widths  divisor, same encoding
- frm  in  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; others are treated as RNE
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts
- result  out  NSIG+NEXP+1  packed binary32
- fflags  out  5  {NV,DZ,OF,UF,NX}

Behaviour:
- Reset values: out_valid=0, result=0, fflags=0, in_ready=1, state IDLE.
- Operand sign = OR of the N_INF, N_ZERO, N_SUBNORMAL and N_NORMAL flags. Result sign = sa XOR sb.
- States: IDLE, DIV, RND, DONE.
  - IDLE: in_ready=1. Accept on in_valid. Register the operands, frm and special-case decode.
  - A special case goes to DONE. Otherwise load remainder=a_sig, divisor=b_sig, cnt=QBITS-1 and go to DIV.
- DIV:
  - Each cycle, trial-subtract divisor from remainder (width NSIG+3).
  - Shift a quotient bit in; shift the remainder left by 1.
  - cnt==0 goes to RND.
- RND:
  - Normalise: if q[QBITS-1]==0, shift q left by 1 and decrement the exponent.
  - Biased exponent = a_exp - b_exp + 127 (NEXP+3 signed).
  - Sticky = (remainder != 0).
  - If biased exponent <= 0: right-shift the significand by 1-biased, saturating at QBITS+1, OR the lost bits into sticky, and use biased exponent 0.
  - Round per frm. A round carry out of the fraction increments the exponent; this also covers subnormal to min-normal.
  - If biased exponent >= 255 after rounding: OF|NX. Result is inf, or max finite 0x7F7FFFFF (with sign) for RTZ, for RDN on a positive result, and for RUP on a negative result.
  - UF when the result is tiny after rounding and inexact. NX when guard|round|sticky is set.
  - Go to DONE.
- DONE: out_valid=1. result and fflags are held stable until out_ready. On the handshake go to IDLE. in_ready=0 in every state except IDLE (no overlap).
- Special cases (resolved in IDLE):
  - Any NaN: canonical 0x7FC00000. NV if either operand is SNAN.
  - 0/0 or inf/inf: 0x7FC00000, NV.
  - Finite nonzero / 0: signed inf, DZ.
  - inf / finite: signed inf, no flags.
  - 0 / nonzero, or finite / inf: signed zero, no flags.
- Latency (clock edges from the accept edge to out_valid high):
  - Special case: 1.
  - Normal: QBITS+2 = 29.
- flush: in any state, return to IDLE next edge with out_valid=0. flush wins over a simultaneous accept or output handshake.
- Reset mid-operation: immediate return to reset values.

Optional Feature:
- Macro FP_DIV_POW2_SHORTCUT_EN.
- When defined: if b_sig == 1.0 (power-of-two divisor), skip DIV. Load q = a_sig aligned to QBITS with remainder 0 and go straight to RND. Latency is 2.
- When undefined: every finite operation iterates; latency is always 29 for non-special inputs.
- Results and flags are identical in both builds.

Decomposition:
- Shared package fp_pkg:
  - NSIG, NEXP and the classifier flag indices (SNAN..N_NORMAL).
  - Rounding-mode encodings.
  - fflags bit positions.
  - CANON_NAN = 0x7FC00000 and MAX_FINITE = 0x7F7FFFFF.
  - State enum.
- One sub-module, fp_round_pack (combinational): takes sign, biased exponent, QBITS significand, sticky and frm; returns the packed result and the OF/UF/NX flags. It is reusable by future multiply/sqrt units.

Test Plan:
- 0x40C00000 / 0x40000000, RNE -> 0x40400000, fflags=0, out_valid 29 edges after accept.
- 0x3F800000 / 0x40400000, RNE -> 0x3EAAAAAB, NX. Same operands with RTZ -> 0x3EAAAAAA, NX.
- 0x3F800000 / 0x00000000 -> 0x7F800000, DZ, latency 1. 0/0 -> 0x7FC00000, NV. sNaN 0x7FA00000 / 1.0 -> 0x7FC00000, NV.
- 0x00800000 / 0x40000000 -> 0x00400000, fflags=0. 0x7F7FFFFF / 0x3F000000: RNE -> 0x7F800000 OF|NX; RTZ -> 0x7F7FFFFF OF|NX.
- Hold out_ready=0 for 5 cycles -> result stable, in_ready=0. Release -> IDLE, next op accepted on the following edge.
- Assert flush at DIV cycle 10 -> no out_valid. The next op 6.0/2.0 completes correctly. Assert rst_n=0 mid-DIV -> all outputs at reset values immediately.
